instruction_fetch: RTL

//  Fetch stage upstream of instruction_memory. Owns the PC and issues word fetches
//  (imem_req/imem_addr), capturing the same-cycle combinational imem_data.

---
 rtl/rv_fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 52 +++++
 rtl/instruction_fetch.sv | 93 +++++++++
 3 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package rv_fetch_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int unsigned INSTR_BYTES = 4;

    // A fetch PC is legal when word aligned and the whole word lies at or below last_byte.
    // The sum is done in 33 bits so a PC near 2**32 cannot wrap into the legal range.
    function automatic logic pc_legal(input logic [31:0] pc, input logic [32:0] last_byte);
        return (pc[1:0] == 2'b00) && (({1'b0, pc} + 33'd3) <= last_byte);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer holding fetched instructions with their PCs.
module fetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type T = fetch_entry_t,
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output T              head
);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign push_ok = push && (count != CW'(DEPTH));
    assign pop_ok  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy tracking; flush empties the buffer and beats any push.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_next(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_next(rd_ptr);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Entry storage; contents only matter while counted as occupied.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues word fetches, buffers results for decode.
module instruction_fetch
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        fetch_fault
);

    localparam int unsigned CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [32:0] LAST_BYTE = 33'((64'd1 << ADDR_WIDTH) - 64'd1);

    fetch_state_t  state;
    fetch_state_t  next_state;
    logic [31:0]   pc;
    logic [31:0]   next_pc;
    logic          pc_ok;
    logic          push;
    logic          flush;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  entry;

    assign pc_ok = pc_legal(pc, LAST_BYTE);
    assign entry = '{pc: pc, instr: imem_data};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (entry),
        .pop       (id_valid && id_ready),
        .flush     (flush),
        .count     (count),
        .head      (head)
    );

    // PC and FSM state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= next_state;
            pc    <= next_pc;
        end
    end

    // Redirect wins over everything; otherwise fetch while legal and the buffer has room.
    // Push gating looks only at occupancy so id_ready never reaches imem_req.
    always_comb begin
        next_state = state;
        next_pc    = pc;
        push       = 1'b0;
        flush      = 1'b0;
        if (redirect_valid) begin
            flush   = 1'b1;
            next_pc = redirect_pc;
            if (state == FAULT && pc_legal(redirect_pc, LAST_BYTE)) next_state = RUN;
        end else if (state == RUN) begin
            if (!pc_ok) begin
                next_state = FAULT;
            end else if (count < CW'(FIFO_DEPTH)) begin
                push    = 1'b1;
                next_pc = pc + 32'(INSTR_BYTES);
            end
        end
    end

    assign imem_req    = rst_n && push;
    assign imem_addr   = pc;
    assign id_valid    = rst_n && (count != '0);
    assign id_instr    = id_valid ? head.instr : '0;
    assign id_pc       = id_valid ? head.pc : '0;
    assign fetch_fault = rst_n && (state == FAULT);

endmodule
